// File: rtl/periph_bridge_pkg.sv
// Shared types and default constants for the CPU-to-peripheral bridge.
// The default window map covers DRAM, the switches, the digits and the LEDs.
package periph_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0]  BRG_DEFAULT_RDATA = 32'hDEAD_BFEE;

  localparam logic [127:0] BRG_DEFAULT_BASE = {
    32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F020, 32'h0000_0000
  };

  localparam logic [127:0] BRG_DEFAULT_MASK = {
    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFC_0000
  };

  // Width of a slot index; a single slot still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: matches an address against N_SLV base/mask
// windows and reports the lowest-index hit as both one-hot and binary index.
module bridge_addr_decode
  import periph_bridge_pkg::*;
#(
  parameter int                    N_SLV    = 4,
  parameter logic [32*N_SLV-1:0]   SLV_BASE = BRG_DEFAULT_BASE,
  parameter logic [32*N_SLV-1:0]   SLV_MASK = BRG_DEFAULT_MASK,
  localparam int                   IDX_W    = idx_width(N_SLV)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [N_SLV-1:0] onehot,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path through this block leaves a value unassigned (no latches).
    hit    = 1'b0;
    index  = '0;
    onehot = '0;
    // Scan downward so the lowest matching slot is the last one written.
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((addr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
        hit   = 1'b1;
        index = IDX_W'(k);
      end
    end
    if (hit) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/periph_bridge.sv
// Registered CPU-to-peripheral bridge: one outstanding access, per-slave
// acknowledge with timeout, single-cycle ready pulse back to the CPU.
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int                  N_SLV         = 4,
  parameter int                  DATA_W        = 32,
  parameter logic [32*N_SLV-1:0] SLV_BASE      = BRG_DEFAULT_BASE,
  parameter logic [32*N_SLV-1:0] SLV_MASK      = BRG_DEFAULT_MASK,
  parameter int                  TIMEOUT       = 255,
  parameter logic [DATA_W-1:0]   DEFAULT_RDATA = BRG_DEFAULT_RDATA
) (
  input  logic                    clk_from_cpu,
  input  logic                    rst_from_cpu,
  input  logic                    req_from_cpu,
  input  logic                    we_from_cpu,
  input  logic [31:0]             addr_from_cpu,
  input  logic [DATA_W-1:0]       wdata_from_cpu,
  input  logic [DATA_W/8-1:0]     wstrb_from_cpu,
  output logic                    ready_to_cpu,
  output logic [DATA_W-1:0]       rdata_to_cpu,
  output logic                    err_to_cpu,
  output logic [15:0]             err_cnt,
  output logic [N_SLV-1:0]        sel_to_slv,
  output logic                    we_to_slv,
  output logic [31:0]             addr_to_slv,
  output logic [DATA_W-1:0]       wdata_to_slv,
  output logic [DATA_W/8-1:0]     wstrb_to_slv,
  input  logic [N_SLV-1:0]        ack_from_slv,
  input  logic [N_SLV*DATA_W-1:0] rdata_from_slv
);

  localparam int IDX_W = idx_width(N_SLV);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  sel_idx;

  logic              dec_hit;
  logic [N_SLV-1:0]  dec_onehot;
  logic [IDX_W-1:0]  dec_index;

  logic              accept;
  logic              done_ok;
  logic              done_err;
  logic              slot_ack;
  logic [DATA_W-1:0] slot_rdata;

  bridge_addr_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr   (addr_from_cpu),
    .hit    (dec_hit),
    .onehot (dec_onehot),
    .index  (dec_index)
  );

  // Only the slot latched at accept time can complete the access.
  assign slot_ack   = ack_from_slv[sel_idx];
  assign slot_rdata = rdata_from_slv[DATA_W*sel_idx +: DATA_W];

  always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_from_cpu) state <= ST_IDLE;
    else               state <= state_d;
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_from_cpu) begin
          accept = 1'b1;
          if (dec_hit) begin
            state_d = ST_ACCESS;
          end else begin
            state_d  = ST_RESP;
            done_err = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (slot_ack) begin
          state_d = ST_RESP;
          done_ok = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d  = ST_RESP;
          done_err = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_from_cpu or negedge rst_from_cpu) begin
    if (!rst_from_cpu) begin
      cnt          <= '0;
      sel_idx      <= '0;
      sel_to_slv   <= '0;
      we_to_slv    <= 1'b0;
      addr_to_slv  <= '0;
      wdata_to_slv <= '0;
      wstrb_to_slv <= '0;
      ready_to_cpu <= 1'b0;
      rdata_to_cpu <= '0;
      err_to_cpu   <= 1'b0;
      err_cnt      <= '0;
    end else begin
      ready_to_cpu <= done_ok | done_err;

      if (accept) begin
        we_to_slv    <= we_from_cpu;
        addr_to_slv  <= addr_from_cpu;
        wdata_to_slv <= wdata_from_cpu;
        wstrb_to_slv <= wstrb_from_cpu;
        sel_to_slv   <= dec_onehot;
        sel_idx      <= dec_index;
        cnt          <= '0;
      end else if (state == ST_ACCESS) begin
        cnt <= cnt + 1'b1;
      end

      if (done_ok) begin
        sel_to_slv   <= '0;
        err_to_cpu   <= 1'b0;
        rdata_to_cpu <= we_to_slv ? '0 : slot_rdata;
      end

      if (done_err) begin
        sel_to_slv   <= '0;
        err_to_cpu   <= 1'b1;
        rdata_to_cpu <= DEFAULT_RDATA;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_periph_bridge.sv
// Self-checking bench for periph_bridge: directed cases plus randomized
// accesses, compared against a transaction-level model of the bridge.
module tb_periph_bridge;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TO    = 4;
  localparam int NEVER = 1000;
  // Slot 3 overlaps slot 2 (0xFFFF_F060..F06F) to exercise lowest-index priority.
  localparam logic [127:0] BASE = {32'hFFFF_F060, 32'hFFFF_F060, 32'hFFFF_F020, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFC_0000};
  localparam logic [31:0]  DEF  = 32'hDEAD_BFEE;

  logic            clk_from_cpu = 1'b0;
  logic            rst_from_cpu;
  logic            req_from_cpu;
  logic            we_from_cpu;
  logic [31:0]     addr_from_cpu;
  logic [DW-1:0]   wdata_from_cpu;
  logic [DW/8-1:0] wstrb_from_cpu;
  logic            ready_to_cpu;
  logic [DW-1:0]   rdata_to_cpu;
  logic            err_to_cpu;
  logic [15:0]     err_cnt;
  logic [N-1:0]    sel_to_slv;
  logic            we_to_slv;
  logic [31:0]     addr_to_slv;
  logic [DW-1:0]   wdata_to_slv;
  logic [DW/8-1:0] wstrb_to_slv;
  logic [N-1:0]    ack_from_slv;
  logic [N*DW-1:0] rdata_from_slv;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err_cnt = 0;

  // Current transaction description
  logic            t_we;
  logic [31:0]     t_addr;
  logic [DW-1:0]   t_wdata;
  logic [DW/8-1:0] t_wstrb;
  int              t_wait;
  bit              t_hold;
  bit              t_stray;

  periph_bridge #(
    .N_SLV         (N),
    .DATA_W        (DW),
    .SLV_BASE      (BASE),
    .SLV_MASK      (MASK),
    .TIMEOUT       (TO),
    .DEFAULT_RDATA (DEF)
  ) dut (
    .clk_from_cpu   (clk_from_cpu),
    .rst_from_cpu   (rst_from_cpu),
    .req_from_cpu   (req_from_cpu),
    .we_from_cpu    (we_from_cpu),
    .addr_from_cpu  (addr_from_cpu),
    .wdata_from_cpu (wdata_from_cpu),
    .wstrb_from_cpu (wstrb_from_cpu),
    .ready_to_cpu   (ready_to_cpu),
    .rdata_to_cpu   (rdata_to_cpu),
    .err_to_cpu     (err_to_cpu),
    .err_cnt        (err_cnt),
    .sel_to_slv     (sel_to_slv),
    .we_to_slv      (we_to_slv),
    .addr_to_slv    (addr_to_slv),
    .wdata_to_slv   (wdata_to_slv),
    .wstrb_to_slv   (wstrb_to_slv),
    .ack_from_slv   (ack_from_slv),
    .rdata_from_slv (rdata_from_slv)
  );

  always #5 clk_from_cpu = ~clk_from_cpu;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lowest-index window whose masked address equals its base; -1 on miss.
  function automatic int ref_decode(input logic [31:0] a);
    for (int k = 0; k < N; k++)
      if ((a & MASK[32*k +: 32]) == BASE[32*k +: 32]) return k;
    return -1;
  endfunction

  task automatic rand_slaves();
    for (int k = 0; k < N; k++) rdata_from_slv[DW*k +: DW] = $urandom();
  endtask

  task automatic drive_req();
    req_from_cpu   = 1'b1;
    we_from_cpu    = t_we;
    addr_from_cpu  = t_addr;
    wdata_from_cpu = t_wdata;
    wstrb_from_cpu = t_wstrb;
  endtask

  // Starts at a negedge with req already driven; ends at a negedge with
  // the bridge idle. Expected timing: request accepted at edge t0, done at
  // edge t0+d, ready visible between t0+d and t0+d+1.
  task automatic run_txn();
    int           slot;
    int           d;
    logic         err_e;
    logic [31:0]  rd_e;
    logic [N-1:0] oh;
    slot = ref_decode(t_addr);
    oh   = '0;
    if (slot >= 0) oh[slot] = 1'b1;
    if (slot < 0) begin
      d = 0; err_e = 1'b1;
    end else if (t_wait + 1 <= TO) begin
      d = t_wait + 1; err_e = 1'b0;
    end else begin
      d = TO; err_e = 1'b1;
    end
    if (err_e)     rd_e = DEF;
    else if (t_we) rd_e = '0;
    else           rd_e = rdata_from_slv[DW*slot +: DW];
    if (err_e && exp_err_cnt < 65535) exp_err_cnt++;

    @(posedge clk_from_cpu);
    for (int j = 0; j <= d + 1; j++) begin
      @(negedge clk_from_cpu);
      if (j == 0 && !t_hold) req_from_cpu = 1'b0;
      if (j == d + 1)        req_from_cpu = 1'b0;
      check("ready", ready_to_cpu, (j == d));
      check("sel", sel_to_slv, (j < d) ? oh : '0);
      check("we_to_slv", we_to_slv, t_we);
      check("addr_to_slv", addr_to_slv, t_addr);
      check("wdata_to_slv", wdata_to_slv, t_wdata);
      check("wstrb_to_slv", wstrb_to_slv, t_wstrb);
      if (j >= d) check("rdata", rdata_to_cpu, rd_e);
      if (j == d) begin
        check("err", err_to_cpu, err_e);
        check("err_cnt", err_cnt, exp_err_cnt[15:0]);
      end
      ack_from_slv = t_stray ? ~oh : '0;
      if (slot >= 0 && j == t_wait) ack_from_slv = ack_from_slv | oh;
      if (j == d + 1) ack_from_slv = '0;
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] a, input int w,
                        input bit hold, input bit stray);
    t_we    = we;
    t_addr  = a;
    t_wdata = $urandom();
    t_wstrb = 4'($urandom_range(0, 15));
    t_wait  = w;
    t_hold  = hold;
    t_stray = stray;
    drive_req();
    run_txn();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          w;

    rst_from_cpu   = 1'b0;
    req_from_cpu   = 1'b0;
    we_from_cpu    = 1'b0;
    addr_from_cpu  = '0;
    wdata_from_cpu = '0;
    wstrb_from_cpu = '0;
    ack_from_slv   = '0;
    rdata_from_slv = '0;
    repeat (2) @(posedge clk_from_cpu);
    @(negedge clk_from_cpu);
    check("rst_ready", ready_to_cpu, 1'b0);
    check("rst_sel", sel_to_slv, '0);
    check("rst_rdata", rdata_to_cpu, '0);
    check("rst_err", err_to_cpu, 1'b0);
    check("rst_err_cnt", err_cnt, '0);
    check("rst_addr_to_slv", addr_to_slv, '0);
    check("rst_we_to_slv", we_to_slv, 1'b0);
    check("rst_wdata_to_slv", wdata_to_slv, '0);
    check("rst_wstrb_to_slv", wstrb_to_slv, '0);
    rst_from_cpu = 1'b1;
    @(negedge clk_from_cpu);

    // Zero-wait load from DRAM
    rand_slaves();
    rdata_from_slv[0 +: 32] = 32'h1234_5678;
    do_txn(1'b0, 32'h0000_0100, 0, 1'b0, 1'b0);

    // Store to slot 2 with three wait cycles
    rand_slaves();
    t_we = 1'b1; t_addr = 32'hFFFF_F060; t_wdata = 32'h0000_00A5; t_wstrb = 4'b0001;
    t_wait = 3; t_hold = 1'b0; t_stray = 1'b0;
    drive_req();
    run_txn();

    // Decode miss
    rand_slaves();
    do_txn(1'b0, 32'hFFFF_F0F0, 0, 1'b0, 1'b0);

    // Timeout, then ack exactly on the timeout edge
    rand_slaves();
    do_txn(1'b0, 32'hFFFF_F020, NEVER, 1'b0, 1'b0);
    rand_slaves();
    do_txn(1'b0, 32'hFFFF_F020, TO - 1, 1'b0, 1'b0);

    // Overlapping windows and stray acks from other slots
    rand_slaves();
    do_txn(1'b0, 32'hFFFF_F060, 1, 1'b0, 1'b1);
    rand_slaves();
    do_txn(1'b0, 32'hFFFF_F068, 0, 1'b0, 1'b1);
    rand_slaves();
    do_txn(1'b0, 32'h0000_0010, 2, 1'b0, 1'b1);

    // Request held through the response cycle must not start a new access
    rand_slaves();
    do_txn(1'b0, 32'hFFFF_F0F0, 0, 1'b1, 1'b0);

    // Reset in the middle of an access
    rand_slaves();
    t_we = 1'b0; t_addr = 32'hFFFF_F024; t_wdata = '0; t_wstrb = '0;
    t_wait = NEVER; t_hold = 1'b0; t_stray = 1'b0;
    drive_req();
    @(posedge clk_from_cpu);
    @(negedge clk_from_cpu);
    req_from_cpu = 1'b0;
    check("mid_sel", sel_to_slv, 4'b0010);
    @(negedge clk_from_cpu);
    #2 rst_from_cpu = 1'b0;
    #1;
    check("rst_mid_sel", sel_to_slv, '0);
    check("rst_mid_ready", ready_to_cpu, 1'b0);
    check("rst_mid_err_cnt", err_cnt, '0);
    exp_err_cnt = 0;
    t_we = 1'b0; t_addr = 32'h0000_0200; t_wdata = 32'h0BAD_F00D; t_wstrb = 4'hF;
    t_wait = 1;
    drive_req();
    @(negedge clk_from_cpu);
    check("rst_hold_ready", ready_to_cpu, 1'b0);
    check("rst_hold_sel", sel_to_slv, '0);
    rst_from_cpu = 1'b1;
    run_txn();

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0:       a = {14'd0, r[17:0]};
        1:       a = 32'hFFFF_F020 | (r & 32'h7);
        2:       a = 32'hFFFF_F060 | (r & 32'h3);
        3:       a = 32'hFFFF_F060 | (r & 32'hF);
        default: a = r;
      endcase
      w = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
      rand_slaves();
      do_txn(1'($urandom_range(0, 1)), a, w, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk_from_cpu);
        check("idle_ready", ready_to_cpu, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
